pc_sequencer: RTL and testbench

Control-flow sequencer that drives the program counter's `reljump_en`, `absjump_en` and `target` inputs each cycle. It sits between the instruction decoder, the ALU compare flags and the PC. It resolves conditional and unconditional branches, calls and returns through a small return-address stack, memory-wait stalls, and halt. It holds the PC without any PC change by issuing an absolute jump to the current PC.

---
 rtl/seq_pkg.sv | 29 ++
 rtl/pc_sequencer_ret_stack.sv | 44 ++++
 rtl/pc_sequencer.sv | 147 ++++++++++++++
 tb/tb_pc_sequencer.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared opcode and state encodings for the program-counter sequencer and its decoder.
package seq_pkg;

    localparam int SEQ_OP_W = 4;

    typedef enum logic [SEQ_OP_W-1:0] {
        OP_NOP  = 4'd0,
        OP_BEQ  = 4'd1,
        OP_BNE  = 4'd2,
        OP_BLT  = 4'd3,
        OP_BGT  = 4'd4,
        OP_JMP  = 4'd5,
        OP_CALL = 4'd6,
        OP_RET  = 4'd7,
        OP_MEM  = 4'd8,
        OP_HALT = 4'd9
    } seq_op_t;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_HALT  = 2'd2
    } seq_state_t;

    function automatic logic is_cond_branch(input seq_op_t op);
        return (op == OP_BEQ) || (op == OP_BNE) || (op == OP_BLT) || (op == OP_BGT);
    endfunction

endpackage

// File: rtl/pc_sequencer_ret_stack.sv
// Return-address LIFO; only the occupancy count is reset, entries keep stale data.
module ret_stack #(
    parameter int D     = 12,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [D-1:0]               din,
    output logic [D-1:0]               top,
    output logic [$clog2(DEPTH):0]     sp,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);

    logic [D-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] top_idx;

    assign wr_idx  = sp[AW-1:0];
    assign top_idx = sp[AW-1:0] - {{(AW-1){1'b0}}, 1'b1};
    assign top     = mem[top_idx];
    assign full    = (sp == ($clog2(DEPTH)+1)'(DEPTH));
    assign empty   = (sp == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            sp <= '0;
        end else if (push && !full) begin
            sp <= sp + 1'b1;
        end else if (pop && !empty) begin
            sp <= sp - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full && !reset) begin
            mem[wr_idx] <= din;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Branch/call/return/stall/halt resolution driving the PC jump controls each cycle.
//   state    | meaning
//   ST_RUN   | decode the presented instruction
//   ST_STALL | hold PC until mem_busy drops, then let it increment past MEM
//   ST_HALT  | hold PC forever; only reset exits
module pc_sequencer
    import seq_pkg::*;
#(
    parameter int D     = 12,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   instr_valid,
    input  seq_op_t                op,
    input  logic [D-1:0]           offset,
    input  logic [D-1:0]           abs_target,
    input  logic                   eq,
    input  logic                   lt,
    input  logic                   gt,
    input  logic                   mem_busy,
    input  logic [D-1:0]           pc_in,
    output logic                   reljump_en,
    output logic                   absjump_en,
    output logic [D-1:0]           target,
    output logic                   halted,
    output logic                   stack_err,
    output logic [$clog2(DEPTH):0] sp
);
    seq_state_t   state, nxt_state;
    logic         push, pop, full, empty, set_err, taken;
    logic [D-1:0] top;

    ret_stack #(.D(D), .DEPTH(DEPTH)) u_stack (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (pc_in + {{(D-1){1'b0}}, 1'b1}),
        .top   (top),
        .sp    (sp),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        unique case (op)
            OP_BEQ:  taken = eq;
            OP_BNE:  taken = !eq;
            OP_BLT:  taken = lt;
            OP_BGT:  taken = gt;
            default: taken = 1'b0;
        endcase
    end

    // Hold is an absolute jump to the current PC; reset forces all enables low.
    always_comb begin
        reljump_en = 1'b0;
        absjump_en = 1'b0;
        target     = '0;
        push       = 1'b0;
        pop        = 1'b0;
        set_err    = 1'b0;
        nxt_state  = state;
        if (!reset) begin
            case (state)
                ST_RUN: begin
                    if (instr_valid) begin
                        if (is_cond_branch(op) && taken) begin
                            reljump_en = 1'b1;
                            target     = offset;
                        end else begin
                            case (op)
                                OP_JMP: begin
                                    reljump_en = 1'b1;
                                    target     = offset;
                                end
                                OP_CALL: begin
                                    absjump_en = 1'b1;
                                    if (!full) begin
                                        push   = 1'b1;
                                        target = abs_target;
                                    end else begin
                                        target    = pc_in;
                                        set_err   = 1'b1;
                                        nxt_state = ST_HALT;
                                    end
                                end
                                OP_RET: begin
                                    absjump_en = 1'b1;
                                    if (!empty) begin
                                        pop    = 1'b1;
                                        target = top;
                                    end else begin
                                        target    = pc_in;
                                        set_err   = 1'b1;
                                        nxt_state = ST_HALT;
                                    end
                                end
                                OP_MEM: begin
                                    if (mem_busy) begin
                                        absjump_en = 1'b1;
                                        target     = pc_in;
                                        nxt_state  = ST_STALL;
                                    end
                                end
                                OP_HALT: begin
                                    absjump_en = 1'b1;
                                    target     = pc_in;
                                    nxt_state  = ST_HALT;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                ST_STALL: begin
                    if (mem_busy) begin
                        absjump_en = 1'b1;
                        target     = pc_in;
                    end else begin
                        nxt_state = ST_RUN;
                    end
                end
                default: begin
                    absjump_en = 1'b1;
                    target     = pc_in;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_RUN;
            stack_err <= 1'b0;
        end else begin
            state <= nxt_state;
            if (set_err) begin
                stack_err <= 1'b1;
            end
        end
    end

    assign halted = (state == ST_HALT);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed scoreboard bench for pc_sequencer: branches, call/return, stack errors, stalls, reset.
module tb_pc_sequencer;
    import seq_pkg::*;

    localparam int D     = 12;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic         rel;
        logic         abs;
        logic [D-1:0] tgt;
        logic         halted;
        logic         err;
        logic [2:0]   sp;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset, instr_valid, eq, lt, gt, mem_busy;
    seq_op_t      op;
    logic [D-1:0] offset, abs_target, pc_in;
    logic         reljump_en, absjump_en, halted, stack_err;
    logic [D-1:0] target;
    logic [2:0]   sp;

    exp_t         sb[$];
    int           n_checks = 0;
    int           n_pass   = 0;
    logic [D-1:0] pc_model;

    pc_sequencer #(.D(D), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .instr_valid (instr_valid),
        .op          (op),
        .offset      (offset),
        .abs_target  (abs_target),
        .eq          (eq),
        .lt          (lt),
        .gt          (gt),
        .mem_busy    (mem_busy),
        .pc_in       (pc_in),
        .reljump_en  (reljump_en),
        .absjump_en  (absjump_en),
        .target      (target),
        .halted      (halted),
        .stack_err   (stack_err),
        .sp          (sp)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    endtask

    // One cycle: drive inputs after the falling edge, sample mid-phase, compare to queued expectation.
    task automatic step(input string tag, input logic rst, input logic v, input seq_op_t o,
                        input logic [D-1:0] off, input logic [D-1:0] abst,
                        input logic e, input logic l, input logic g, input logic busy,
                        input logic [D-1:0] pc,
                        input logic xrel, input logic xabs, input logic [D-1:0] xtgt,
                        input logic xh, input logic xe, input logic [2:0] xsp);
        exp_t x;
        @(negedge clk);
        reset = rst; instr_valid = v; op = o; offset = off; abs_target = abst;
        eq = e; lt = l; gt = g; mem_busy = busy; pc_in = pc;
        sb.push_back('{rel: xrel, abs: xabs, tgt: xtgt, halted: xh, err: xe, sp: xsp});
        #2;
        x = sb.pop_front();
        check({tag, ".rel"},    32'(reljump_en), 32'(x.rel));
        check({tag, ".abs"},    32'(absjump_en), 32'(x.abs));
        check({tag, ".tgt"},    32'(target),     32'(x.tgt));
        check({tag, ".halted"}, 32'(halted),     32'(x.halted));
        check({tag, ".err"},    32'(stack_err),  32'(x.err));
        check({tag, ".sp"},     32'(sp),         32'(x.sp));
        if (absjump_en)      pc_model = target;
        else if (reljump_en) pc_model = pc_model + target;
        else                 pc_model = pc_model + 1'b1;
    endtask

    initial begin
        reset = 1'b1; instr_valid = 1'b0; op = OP_NOP; offset = '0; abs_target = '0;
        eq = 1'b0; lt = 1'b0; gt = 1'b0; mem_busy = 1'b0; pc_in = '0; pc_model = '0;
        repeat (2) @(posedge clk);

        //   tag        rst v  op       off     abs     e  l  g  busy pc      rel abs tgt     h  e  sp
        step("rst",     1, 1, OP_JMP,  12'h003, 12'h000, 0, 0, 0, 0, 12'h00A, 0, 0, 12'h000, 0, 0, 0);
        step("beq_t",   0, 1, OP_BEQ,  12'h005, 12'h000, 1, 0, 0, 0, 12'h00A, 1, 0, 12'h005, 0, 0, 0);
        step("beq_n",   0, 1, OP_BEQ,  12'h005, 12'h000, 0, 0, 0, 0, 12'h00A, 0, 0, 12'h000, 0, 0, 0);
        step("blt_neg", 0, 1, OP_BLT,  12'hFFE, 12'h000, 0, 1, 0, 0, 12'h00A, 1, 0, 12'hFFE, 0, 0, 0);
        step("bne_t",   0, 1, OP_BNE,  12'h004, 12'h000, 0, 0, 0, 0, 12'h00A, 1, 0, 12'h004, 0, 0, 0);
        step("bgt_n",   0, 1, OP_BGT,  12'h004, 12'h000, 1, 1, 0, 0, 12'h00A, 0, 0, 12'h000, 0, 0, 0);
        step("inval",   0, 0, OP_JMP,  12'h004, 12'h000, 0, 0, 0, 0, 12'h00A, 0, 0, 12'h000, 0, 0, 0);
        step("nop",     0, 1, OP_NOP,  12'h004, 12'h000, 1, 1, 1, 0, 12'h00A, 0, 0, 12'h000, 0, 0, 0);
        step("jmp",     0, 1, OP_JMP,  12'h7F0, 12'h000, 0, 0, 0, 0, 12'h00A, 1, 0, 12'h7F0, 0, 0, 0);

        step("call",    0, 1, OP_CALL, 12'h000, 12'h100, 0, 0, 0, 0, 12'h020, 0, 1, 12'h100, 0, 0, 0);
        step("sp1",     0, 1, OP_NOP,  12'h000, 12'h000, 0, 0, 0, 0, 12'h100, 0, 0, 12'h000, 0, 0, 1);
        step("ret",     0, 1, OP_RET,  12'h000, 12'h000, 0, 0, 0, 0, 12'h105, 0, 1, 12'h021, 0, 0, 1);
        step("sp0",     0, 1, OP_NOP,  12'h000, 12'h000, 0, 0, 0, 0, 12'h021, 0, 0, 12'h000, 0, 0, 0);

        step("lifo_c1", 0, 1, OP_CALL, 12'h000, 12'h300, 0, 0, 0, 0, 12'h050, 0, 1, 12'h300, 0, 0, 0);
        step("lifo_c2", 0, 1, OP_CALL, 12'h000, 12'h400, 0, 0, 0, 0, 12'h060, 0, 1, 12'h400, 0, 0, 1);
        step("lifo_r1", 0, 1, OP_RET,  12'h000, 12'h000, 0, 0, 0, 0, 12'h401, 0, 1, 12'h061, 0, 0, 2);
        step("lifo_r2", 0, 1, OP_RET,  12'h000, 12'h000, 0, 0, 0, 0, 12'h062, 0, 1, 12'h051, 0, 0, 1);

        pc_model = 12'h007;
        step("mem_b1",  0, 1, OP_MEM,  12'h000, 12'h000, 0, 0, 0, 1, 12'h007, 0, 1, 12'h007, 0, 0, 0);
        step("mem_b2",  0, 1, OP_JMP,  12'h010, 12'h000, 0, 0, 0, 1, 12'h007, 0, 1, 12'h007, 0, 0, 0);
        step("mem_b3",  0, 1, OP_CALL, 12'h010, 12'h123, 0, 0, 0, 1, 12'h007, 0, 1, 12'h007, 0, 0, 0);
        step("mem_rel", 0, 1, OP_JMP,  12'h010, 12'h000, 0, 0, 0, 0, 12'h007, 0, 0, 12'h000, 0, 0, 0);
        check("mem_pc", 32'(pc_model), 32'h008);
        step("mem_run", 0, 1, OP_NOP,  12'h000, 12'h000, 0, 0, 0, 0, 12'h008, 0, 0, 12'h000, 0, 0, 0);

        step("stl_in",  0, 1, OP_MEM,  12'h000, 12'h000, 0, 0, 0, 1, 12'h009, 0, 1, 12'h009, 0, 0, 0);
        step("stl_rst", 1, 1, OP_MEM,  12'h000, 12'h000, 0, 0, 0, 1, 12'h009, 0, 0, 12'h000, 0, 0, 0);
        step("stl_run", 0, 1, OP_NOP,  12'h000, 12'h000, 0, 0, 0, 1, 12'h009, 0, 0, 12'h000, 0, 0, 0);

        step("ovf_c1",  0, 1, OP_CALL, 12'h000, 12'h200, 0, 0, 0, 0, 12'h030, 0, 1, 12'h200, 0, 0, 0);
        step("ovf_c2",  0, 1, OP_CALL, 12'h000, 12'h200, 0, 0, 0, 0, 12'h031, 0, 1, 12'h200, 0, 0, 1);
        step("ovf_c3",  0, 1, OP_CALL, 12'h000, 12'h200, 0, 0, 0, 0, 12'h032, 0, 1, 12'h200, 0, 0, 2);
        step("ovf_c4",  0, 1, OP_CALL, 12'h000, 12'h200, 0, 0, 0, 0, 12'h033, 0, 1, 12'h200, 0, 0, 3);
        step("ovf_c5",  0, 1, OP_CALL, 12'h000, 12'h200, 0, 0, 0, 0, 12'h040, 0, 1, 12'h040, 0, 0, 4);
        step("ovf_h1",  0, 1, OP_JMP,  12'h005, 12'h000, 0, 0, 0, 0, 12'h040, 0, 1, 12'h040, 1, 1, 4);
        step("ovf_h2",  0, 1, OP_RET,  12'h005, 12'h000, 0, 0, 0, 0, 12'h041, 0, 1, 12'h041, 1, 1, 4);
        step("hlt_rst", 1, 1, OP_JMP,  12'h005, 12'h000, 0, 0, 0, 0, 12'h041, 0, 0, 12'h000, 1, 1, 4);
        step("hlt_run", 0, 1, OP_NOP,  12'h000, 12'h000, 0, 0, 0, 0, 12'h041, 0, 0, 12'h000, 0, 0, 0);

        step("udf_ret", 0, 1, OP_RET,  12'h000, 12'h000, 0, 0, 0, 0, 12'h070, 0, 1, 12'h070, 0, 0, 0);
        step("udf_h",   0, 1, OP_CALL, 12'h000, 12'h200, 0, 0, 0, 0, 12'h070, 0, 1, 12'h070, 1, 1, 0);
        step("udf_rst", 1, 0, OP_NOP,  12'h000, 12'h000, 0, 0, 0, 0, 12'h070, 0, 0, 12'h000, 1, 1, 0);

        step("hop",     0, 1, OP_HALT, 12'h000, 12'h000, 0, 0, 0, 0, 12'h080, 0, 1, 12'h080, 0, 0, 0);
        step("hop_h",   0, 1, OP_BEQ,  12'h003, 12'h000, 1, 0, 0, 0, 12'h081, 0, 1, 12'h081, 1, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
